// File: rtl/uart_cmd_assembler.sv
// UART command assembler: collects BYTES received bytes into one command word, MSB first.
// Optional CHECKSUM_EN macro appends a checksum byte (sum of all bytes mod 256 == 0).
`timescale 1ns/1ps
module uart_cmd_assembler #(
    parameter int BYTES          = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_rdy,
    input  logic [7:0]         rx_data,
    output logic               clr_rx_rdy,
    output logic [8*BYTES-1:0] cmd,
    output logic               cmd_rdy,
    input  logic               clr_cmd_rdy,
    output logic               frame_err,
    output logic               overrun,
    output logic               chk_err
);

`ifdef CHECKSUM_EN
    localparam int TOTAL = BYTES + 1;
`else
    localparam int TOTAL = BYTES;
`endif
    localparam int CMD_W = 8 * BYTES;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [TMR_W-1:0]   timer_q;
    logic [CMD_W-1:0]   asm_q;
    logic [CMD_W-1:0]   cmd_q;
    logic               cmd_rdy_q;
    logic               capture, last, timeout, sum_ok, commit_ok, do_commit;

    // rx_rdy is ignored while in CHECK; the receiver simply holds the byte one more cycle
    assign capture   = (state_q != CHECK) && rx_rdy;
    assign last      = capture && (count_q == CNT_W'(TOTAL - 1));
    assign timeout   = (state_q == COLLECT) && !rx_rdy && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (capture) begin
            sum_q <= (state_q == IDLE) ? rx_data : sum_q + rx_data;
        end
    end

    assign sum_ok  = (sum_q == 8'd0);
    assign chk_err = (state_q == CHECK) && !sum_ok;
`else
    assign sum_ok  = 1'b1;
    assign chk_err = 1'b0;
`endif

    assign commit_ok  = (state_q == CHECK) && sum_ok;
    assign do_commit  = commit_ok && (!cmd_rdy_q || clr_cmd_rdy);
    assign overrun    = commit_ok && cmd_rdy_q && !clr_cmd_rdy;
    assign clr_rx_rdy = capture;
    assign frame_err  = timeout;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = last ? CHECK : COLLECT;
            COLLECT: begin
                if (last)         state_d = CHECK;
                else if (timeout) state_d = IDLE;
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timer_q   <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if ((state_q == CHECK) || timeout) count_q <= '0;
            else if (capture)                  count_q <= count_q + CNT_W'(1);

            if (capture || (state_q != COLLECT)) timer_q <= '0;
            else                                 timer_q <= timer_q + TMR_W'(1);

            // A commit coincident with clr_cmd_rdy keeps cmd_rdy set
            if (do_commit) begin
                cmd_q     <= asm_q;
                cmd_rdy_q <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
        end
    end

    // Checksum byte (index BYTES) is summed but never shifted into the command
    always_ff @(posedge clk) begin
        if (capture && (int'(count_q) < BYTES)) begin
            asm_q <= CMD_W'({asm_q, rx_data});
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench for uart_cmd_assembler: driver queues expected events, monitor pops on DUT output events.
`timescale 1ns/1ps
module tb_uart_cmd_assembler;
    localparam int BYTES = 2;
    localparam int TMO   = 64;
`ifdef CHECKSUM_EN
    localparam int TOTAL = BYTES + 1;
`else
    localparam int TOTAL = BYTES;
`endif

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        frame_err;
    logic        overrun;
    logic        chk_err;

    uart_cmd_assembler #(.BYTES(BYTES), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err),
        .overrun(overrun), .chk_err(chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_COMMIT, EV_FRAME, EV_OVERRUN, EV_CHK} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] val;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_cap = 0;
    int          clr_cnt  = 0;
    logic [15:0] prev_cmd = '0;
    logic        prev_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [15:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input ev_kind_t k, input logic [15:0] v, input string name);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event actual=%s/0x%0h required=none", name, k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val !== v) begin
                failures++;
                $display("FAIL %s actual=%s/0x%0h required=%s/0x%0h", name, k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_cmd = cmd;
            prev_rdy = cmd_rdy;
        end else begin
            if (clr_rx_rdy) clr_cnt++;
            if (frame_err) begin
                pop_ev(EV_FRAME, 16'h0, "frame_err");
                check("frame_err_delay", cyc - last_cap, TMO - 1);
            end
            if (overrun) pop_ev(EV_OVERRUN, 16'h0, "overrun");
            if (chk_err) pop_ev(EV_CHK, 16'h0, "chk_err");
            if ((cmd_rdy && !prev_rdy) || (cmd !== prev_cmd)) begin
                pop_ev(EV_COMMIT, cmd, "commit");
                check("commit_rdy", cmd_rdy, 1);
                check("commit_latency", cyc - last_cap, 1);
            end
            prev_cmd = cmd;
            prev_rdy = cmd_rdy;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (clr_rx_rdy) got = 1;
        end
        check("clr_rx_rdy_seen", got, 1);
        @(posedge clk);
        #1;
        rx_rdy   = 1'b0;
        last_cap = cyc;
    endtask

    task automatic send_cmd(input logic [15:0] c, input int gap);
        send_byte(c[15:8]);
        idle(gap);
        send_byte(c[7:0]);
`ifdef CHECKSUM_EN
        idle(gap);
        send_byte(8'(0 - c[15:8] - c[7:0]));
`endif
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic clear_cmd();
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int clr0;
        rst         = 1'b1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        idle(3);
        check("reset_cmd", cmd, 0);
        check("reset_cmd_rdy", cmd_rdy, 0);
        check("reset_clr_rx_rdy", clr_rx_rdy, 0);
        check("reset_pulses", {frame_err, overrun, chk_err}, 0);
        rst = 1'b0;
        idle(2);

        // Basic command with a long gap between bytes
        clr0 = clr_cnt;
        push_ev(EV_COMMIT, 16'hA53C);
        send_cmd(16'hA53C, 30);
        wait_drain(10, "drain_a53c");
        check("clr_rx_rdy_pulses", clr_cnt - clr0, TOTAL);
        idle(20);
        check("cmd_rdy_held", cmd_rdy, 1);
        check("cmd_held", cmd, 16'hA53C);

        // Overrun: previous command not acknowledged
        push_ev(EV_OVERRUN, 16'h0);
        send_cmd(16'h0102, 3);
        wait_drain(10, "drain_overrun");
        check("overrun_cmd_kept", cmd, 16'hA53C);
        check("overrun_rdy_kept", cmd_rdy, 1);

        // Acknowledge coincident with commit
        push_ev(EV_COMMIT, 16'h0102);
        send_cmd(16'h0102, 3);
        clear_cmd();
        wait_drain(10, "drain_coincident");
        check("coincident_rdy", cmd_rdy, 1);
        check("coincident_cmd", cmd, 16'h0102);

        clear_cmd();
        check("ack_clears_rdy", cmd_rdy, 0);

        // Inter-byte timeout drops partial data
        push_ev(EV_FRAME, 16'h0);
        send_byte(8'h11);
        idle(TMO + 5);
        wait_drain(1, "drain_frame");
        check("frame_rdy_low", cmd_rdy, 0);
        push_ev(EV_COMMIT, 16'h2233);
        send_cmd(16'h2233, 3);
        wait_drain(10, "drain_2233");
        clear_cmd();

        // Reset mid-command
        send_byte(8'h55);
        idle(2);
        rst = 1'b1;
        idle(1);
        check("midrst_cmd", cmd, 0);
        check("midrst_rdy", cmd_rdy, 0);
        check("midrst_outs", {clr_rx_rdy, frame_err, overrun, chk_err}, 0);
        rst = 1'b0;
        idle(1);
        push_ev(EV_COMMIT, 16'h6677);
        send_cmd(16'h6677, 3);
        wait_drain(10, "drain_6677");
        check("cmd_6677", cmd, 16'h6677);
        clear_cmd();

`ifdef CHECKSUM_EN
        push_ev(EV_COMMIT, 16'h1234);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hBA);
        wait_drain(10, "drain_chk_good");
        clear_cmd();
        push_ev(EV_CHK, 16'h0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h00);
        wait_drain(10, "drain_chk_bad");
        check("chk_bad_rdy", cmd_rdy, 0);
        check("chk_bad_cmd", cmd, 16'h1234);
`endif

        idle(5);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
